// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder and the display driver
// that produces the multiplexed scan.
//   - scan_state_e : decoder FSM state encoding
//   - glyph_of()   : hex nibble -> ABCDEFG segment code (A is bit 6)
//   - SEL_ONEHOT   : legal active-low digit select patterns, index = position
//   - sel_legal()/sel_pos() : select classification helpers
package seg_scan_decoder_pkg;

  localparam int NUM_POS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

  // Active-low one-hot: position n is selected when bit n alone is low.
  localparam logic [NUM_POS-1:0][3:0] SEL_ONEHOT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [6:0] glyph_of(input logic [3:0] nib);
    case (nib)
      4'h0: glyph_of = 7'b1111110;
      4'h1: glyph_of = 7'b0110000;
      4'h2: glyph_of = 7'b1101101;
      4'h3: glyph_of = 7'b1111001;
      4'h4: glyph_of = 7'b0110011;
      4'h5: glyph_of = 7'b1011011;
      4'h6: glyph_of = 7'b1011111;
      4'h7: glyph_of = 7'b1110000;
      4'h8: glyph_of = 7'b1111111;
      4'h9: glyph_of = 7'b1111011;
      4'hA: glyph_of = 7'b1110111;
      4'hB: glyph_of = 7'b0011111;
      4'hC: glyph_of = 7'b1001110;
      4'hD: glyph_of = 7'b0111101;
      4'hE: glyph_of = 7'b1001111;
      default: glyph_of = 7'b1000111;
    endcase
  endfunction

  function automatic logic sel_legal(input logic [3:0] an);
    sel_legal = 1'b0;
    for (int i = 0; i < NUM_POS; i++)
      if (an == SEL_ONEHOT[i]) sel_legal = 1'b1;
  endfunction

  function automatic logic [1:0] sel_pos(input logic [3:0] an);
    sel_pos = '0;
    for (int i = 0; i < NUM_POS; i++)
      if (an == SEL_ONEHOT[i]) sel_pos = 2'(i);
  endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scan bus between a multiplexed seven-segment driver and the decoder.
//   master : drives i_anodes/i_segments, observes decoded results
//   slave  : the decoder
//   i_anodes[3:0]   active-low digit select
//   i_segments[7:0] {A,B,C,D,E,F,G,P}, active-high
//   o_data[15:0]    decoded digits {d3,d2,d1,d0}
//   o_dots/o_err    per-position dot and illegal-glyph flags
//   o_valid         one-cycle new-frame pulse
//   o_glitch        one-cycle pulse after a multi-select sample
interface seg_scan_decoder_if;
  logic [3:0]  i_anodes;
  logic [7:0]  i_segments;
  logic [15:0] o_data;
  logic [3:0]  o_dots;
  logic [3:0]  o_err;
  logic        o_valid;
  logic        o_glitch;

  modport master (output i_anodes, i_segments,
                  input  o_data, o_dots, o_err, o_valid, o_glitch);
  modport slave  (input  i_anodes, i_segments,
                  output o_data, o_dots, o_err, o_valid, o_glitch);
endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational ABCDEFG glyph -> hex nibble lookup.
//   glyph_i[6:0] : segment pattern, A in bit 6
//   nib_o[3:0]   : decoded nibble (0 when illegal)
//   illegal_o    : pattern matches none of the 16 hex glyphs
module seg_glyph_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] glyph_i,
  output logic [3:0] nib_o,
  output logic       illegal_o
);

  always_comb begin
    nib_o     = '0;
    illegal_o = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (glyph_i == glyph_of(4'(n))) begin
        nib_o     = 4'(n);
        illegal_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers four hex digits from a multiplexed seven-segment scan.
// A digit is captured once its select+segment sample has been stable for
// STABLE_CYCLES consecutive cycles; when all four positions have been
// captured the frame is published on o_data/o_dots/o_err with an o_valid pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : scan bus, slave side (see seg_scan_decoder_if)
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_decoder_if.slave bus
);

  localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

  scan_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0][3:0] stg_nib_q, stg_nib_d;
  logic [3:0]  stg_dot_q, stg_dot_d;
  logic [3:0]  stg_err_q, stg_err_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  dots_q, dots_d;
  logic [3:0]  err_q, err_d;
  logic        valid_q, valid_d;
  logic        glitch_q, glitch_d;

  logic       legal, same, capture;
  logic [1:0] pos;
  logic [3:0] nib;
  logic       illegal;

  assign legal = sel_legal(bus.i_anodes);
  assign pos   = sel_pos(bus.i_anodes);
  assign same  = (bus.i_anodes == an_q) && (bus.i_segments == seg_q);

  seg_glyph_decode u_dec (
    .glyph_i   (bus.i_segments[7:1]),
    .nib_o     (nib),
    .illegal_o (illegal)
  );

  // FSM: next state, stability counter and reference sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    an_d    = an_q;
    seg_d   = seg_q;
    capture = 1'b0;

    if (!legal) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (same) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          end else begin
            cnt_d = 8'd1;
            an_d  = bus.i_anodes;
            seg_d = bus.i_segments;
          end
        end
        ST_HELD: begin
          if (!same) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd1;
            an_d    = bus.i_anodes;
            seg_d   = bus.i_segments;
          end
        end
        default: begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
          an_d    = bus.i_anodes;
          seg_d   = bus.i_segments;
        end
      endcase
    end

    // Capture on the cycle the count reaches the threshold; this also covers
    // STABLE_CYCLES=1, where a freshly loaded count of 1 captures at once.
    if (state_d == ST_SETTLE && cnt_d == STAB) begin
      capture = 1'b1;
      state_d = ST_HELD;
    end
  end

  // Staging, frame assembly and output registers.
  always_comb begin
    mask_d    = mask_q;
    stg_nib_d = stg_nib_q;
    stg_dot_d = stg_dot_q;
    stg_err_d = stg_err_q;
    data_d    = data_q;
    dots_d    = dots_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    // Not legal and not all-high means two or more selects low.
    glitch_d  = !legal && (bus.i_anodes != 4'hF);

    if (capture) begin
      stg_nib_d[pos] = nib;
      stg_dot_d[pos] = bus.i_segments[0];
      stg_err_d[pos] = illegal;
      mask_d         = mask_q | (4'b0001 << pos);
      if (mask_d == 4'hF) begin
        data_d  = stg_nib_d;
        dots_d  = stg_dot_d;
        err_d   = stg_err_d;
        valid_d = 1'b1;
        mask_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      an_q      <= '0;
      seg_q     <= '0;
      mask_q    <= '0;
      stg_nib_q <= '0;
      stg_dot_q <= '0;
      stg_err_q <= '0;
      data_q    <= '0;
      dots_q    <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      glitch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      mask_q    <= mask_d;
      stg_nib_q <= stg_nib_d;
      stg_dot_q <= stg_dot_d;
      stg_err_q <= stg_err_d;
      data_q    <= data_d;
      dots_q    <= dots_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      glitch_q  <= glitch_d;
    end
  end

  assign bus.o_data   = data_q;
  assign bus.o_dots   = dots_q;
  assign bus.o_err    = err_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_glitch = glitch_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: two instances (STABLE_CYCLES 4 and 1) share one
// stimulus stream and are compared every cycle against a run-length model.
module tb_seg_scan_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] an = 4'hF;
  logic [7:0] sg = 8'h00;

  seg_scan_decoder_if bus4 ();
  seg_scan_decoder_if bus1 ();
  assign bus4.i_anodes = an;
  assign bus4.i_segments = sg;
  assign bus1.i_anodes = an;
  assign bus1.i_segments = sg;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  seg_scan_decoder #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int tests = 0;
  int fails = 0;
  int vcnt4 = 0;
  int vcnt1 = 0;

  logic [6:0] REF_GLYPH [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  int STAB [2] = '{4, 1};

  // Model: a digit is captured when the same legal sample has been seen for
  // exactly STAB consecutive cycles.
  int          run [2];
  logic [3:0]  l_an [2];
  logic [7:0]  l_sg [2];
  bit          l_leg [2];
  logic [3:0]  s_nib [2][4];
  logic        s_dot [2][4];
  logic        s_err [2][4];
  logic [3:0]  m_mask [2];
  logic [15:0] e_data [2];
  logic [3:0]  e_dots [2];
  logic [3:0]  e_err [2];
  logic        e_valid [2];
  logic        e_glitch [2];

  typedef struct packed {
    logic [6:0] g;
    logic [3:0] nib;
    logic       err;
  } vec_t;
  vec_t vtab [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ref_decode(input logic [6:0] g, output logic [3:0] n, output logic e);
    n = 4'h0;
    e = 1'b1;
    for (int i = 0; i < 16; i++)
      if (REF_GLYPH[i] == g) begin n = 4'(i); e = 1'b0; end
  endtask

  task automatic model_clear(input int k);
    run[k] = 0; l_leg[k] = 0; l_an[k] = 4'hF; l_sg[k] = 8'h00;
    m_mask[k] = 4'h0; e_data[k] = 16'h0; e_dots[k] = 4'h0; e_err[k] = 4'h0;
    e_valid[k] = 1'b0; e_glitch[k] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_nib[k][i] = 4'h0; s_dot[k][i] = 1'b0; s_err[k][i] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] a, input logic [7:0] s);
    int lows;
    int p;
    logic [3:0] n;
    logic e;
    lows = $countones(~a);
    e_valid[k] = 1'b0;
    e_glitch[k] = (lows >= 2);
    if (lows == 1) begin
      if (l_leg[k] && a == l_an[k] && s == l_sg[k]) run[k]++;
      else run[k] = 1;
      if (run[k] == STAB[k]) begin
        p = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) p = i;
        ref_decode(s[7:1], n, e);
        s_nib[k][p] = n; s_dot[k][p] = s[0]; s_err[k][p] = e;
        m_mask[k][p] = 1'b1;
        if (m_mask[k] == 4'hF) begin
          for (int i = 0; i < 4; i++) begin
            e_data[k][4*i +: 4] = s_nib[k][i];
            e_dots[k][i] = s_dot[k][i];
            e_err[k][i] = s_err[k][i];
          end
          e_valid[k] = 1'b1;
          m_mask[k] = 4'h0;
        end
      end
    end else begin
      run[k] = 0;
    end
    l_leg[k] = (lows == 1); l_an[k] = a; l_sg[k] = s;
  endtask

  function automatic logic [25:0] get_out(input int k);
    if (k == 0) return {bus4.o_data, bus4.o_dots, bus4.o_err, bus4.o_valid, bus4.o_glitch};
    return {bus1.o_data, bus1.o_dots, bus1.o_err, bus1.o_valid, bus1.o_glitch};
  endfunction

  task automatic step(input logic [3:0] a, input logic [7:0] s);
    an = a; sg = s;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, a, s);
    #1;
    for (int k = 0; k < 2; k++)
      chk(k == 0 ? "cycle_s4" : "cycle_s1", 32'(get_out(k)),
          32'({e_data[k], e_dots[k], e_err[k], e_valid[k], e_glitch[k]}));
    if (bus4.o_valid) vcnt4++;
    if (bus1.o_valid) vcnt1++;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) model_clear(k);
    repeat (cycles) @(posedge clk);
    #1;
    chk("reset_s4", 32'(get_out(0)), 32'h0);
    chk("reset_s1", 32'(get_out(1)), 32'h0);
    rst_n = 1'b1;
    vcnt4 = 0; vcnt1 = 0;
  endtask

  task automatic show(input int p, input logic [6:0] g, input logic d, input int cycles);
    logic [3:0] a;
    a = 4'hF;
    a[p] = 1'b0;
    repeat (cycles) step(a, {g, d});
  endtask

  initial begin
    vtab[0]  = '{7'b1111110, 4'h0, 1'b0};
    vtab[1]  = '{7'b0110000, 4'h1, 1'b0};
    vtab[2]  = '{7'b1101101, 4'h2, 1'b0};
    vtab[3]  = '{7'b1111001, 4'h3, 1'b0};
    vtab[4]  = '{7'b0110011, 4'h4, 1'b0};
    vtab[5]  = '{7'b1011011, 4'h5, 1'b0};
    vtab[6]  = '{7'b1011111, 4'h6, 1'b0};
    vtab[7]  = '{7'b1110000, 4'h7, 1'b0};
    vtab[8]  = '{7'b1111111, 4'h8, 1'b0};
    vtab[9]  = '{7'b1111011, 4'h9, 1'b0};
    vtab[10] = '{7'b1110111, 4'hA, 1'b0};
    vtab[11] = '{7'b0011111, 4'hB, 1'b0};
    vtab[12] = '{7'b1001110, 4'hC, 1'b0};
    vtab[13] = '{7'b0111101, 4'hD, 1'b0};
    vtab[14] = '{7'b1001111, 4'hE, 1'b0};
    vtab[15] = '{7'b1000111, 4'hF, 1'b0};
    vtab[16] = '{7'b0000000, 4'h0, 1'b1};
    vtab[17] = '{7'b0000001, 4'h0, 1'b1};
    vtab[18] = '{7'b1111100, 4'h0, 1'b1};
    vtab[19] = '{7'b0100000, 4'h0, 1'b1};

    do_reset(3);

    // Glyph table: each vector fills all four positions, dot on odd positions.
    for (int v = 0; v < 20; v++) begin
      for (int p = 0; p < 4; p++) show(p, vtab[v].g, p[0], 5);
      chk($sformatf("vec%0d_data", v), 32'(bus4.o_data), 32'({4{vtab[v].nib}}));
      chk($sformatf("vec%0d_err", v), 32'(bus4.o_err), 32'({4{vtab[v].err}}));
      chk($sformatf("vec%0d_dots", v), 32'(bus4.o_dots), 32'(4'b1010));
    end
    chk("vec_valid_count", 32'(vcnt4), 32'd20);

    // Illegal glyph held on position 2.
    do_reset(1);
    show(0, REF_GLYPH[5], 1'b0, 5); show(1, REF_GLYPH[5], 1'b0, 5);
    show(2, 7'b0000001, 1'b0, 10);  show(3, REF_GLYPH[5], 1'b0, 5);
    chk("illegal_err", 32'(bus4.o_err), 32'(4'b0100));
    chk("illegal_nib2", 32'(bus4.o_data[11:8]), 32'h0);

    // Short-lived 8 then a stable 3 on position 1.
    do_reset(1);
    show(0, REF_GLYPH[1], 1'b0, 5);
    show(1, REF_GLYPH[8], 1'b0, 3); show(1, REF_GLYPH[3], 1'b0, 5);
    show(2, REF_GLYPH[1], 1'b0, 5); show(3, REF_GLYPH[1], 1'b0, 5);
    chk("settle_nib1_s4", 32'(bus4.o_data[7:4]), 32'h3);
    chk("settle_nib1_s1", 32'(bus1.o_data[7:4]), 32'h3);
    chk("settle_valid", 32'(vcnt4), 32'd1);

    // Multi-select glitch mid-frame.
    do_reset(1);
    show(0, REF_GLYPH[2], 1'b0, 5); show(1, REF_GLYPH[2], 1'b0, 5);
    step(4'b0011, {REF_GLYPH[9], 1'b0});
    chk("glitch_pulse", 32'(bus4.o_glitch), 32'd1);
    show(2, REF_GLYPH[2], 1'b0, 5);
    chk("glitch_clear", 32'(bus4.o_glitch), 32'd0);
    show(3, REF_GLYPH[2], 1'b0, 5);
    chk("glitch_frame_valid", 32'(vcnt4), 32'd1);
    chk("glitch_frame_data", 32'(bus4.o_data), 32'h2222);

    // Reset after three captures discards them.
    do_reset(1);
    show(0, REF_GLYPH[4], 1'b1, 5); show(1, REF_GLYPH[4], 1'b1, 5); show(2, REF_GLYPH[4], 1'b1, 5);
    do_reset(2);
    show(0, REF_GLYPH[6], 1'b0, 5); show(1, REF_GLYPH[6], 1'b0, 5); show(2, REF_GLYPH[6], 1'b0, 5);
    chk("rst_no_valid", 32'(vcnt4), 32'd0);
    show(3, REF_GLYPH[6], 1'b0, 5);
    chk("rst_valid_after4", 32'(vcnt4), 32'd1);
    chk("rst_data", 32'(bus4.o_data), 32'h6666);

    // Long dwell on one position.
    do_reset(1);
    show(0, REF_GLYPH[7], 1'b0, 100);
    show(1, REF_GLYPH[0], 1'b0, 5); show(2, REF_GLYPH[0], 1'b0, 5); show(3, REF_GLYPH[0], 1'b0, 5);
    chk("dwell_valid_s4", 32'(vcnt4), 32'd1);
    chk("dwell_valid_s1", 32'(vcnt1), 32'd1);
    chk("dwell_data", 32'(bus4.o_data), 32'h0007);

    // Loopback from a behavioural scan driver: 6-bit dwell counter.
    do_reset(1);
    for (int c = 0; c < 1024; c++) begin
      logic [15:0] dat;
      logic [3:0] dts;
      logic [3:0] a;
      logic [3:0] nb;
      int p;
      dat = 16'hBEEF; dts = 4'b0101;
      p = (c >> 6) & 3;
      nb = dat[4*p +: 4];
      a = 4'hF; a[p] = 1'b0;
      step(a, {REF_GLYPH[nb], dts[p]});
    end
    chk("loop_data", 32'(bus4.o_data), 32'hBEEF);
    chk("loop_dots", 32'(bus4.o_dots), 32'(4'b0101));
    chk("loop_err", 32'(bus4.o_err), 32'h0);
    chk("loop_frames", 32'(vcnt4), 32'd4);

    // Random scan traffic checked cycle by cycle.
    do_reset(1);
    for (int n = 0; n < 700; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind <= 7) begin
        logic [6:0] g;
        g = ($urandom_range(0, 7) == 0) ? 7'($urandom) : REF_GLYPH[$urandom_range(0, 15)];
        show(int'($urandom_range(0, 3)), g, 1'($urandom), int'($urandom_range(1, 7)));
      end else if (kind == 8) begin
        repeat ($urandom_range(1, 3)) step(4'hF, 8'($urandom));
      end else begin
        logic [3:0] a;
        a = 4'($urandom);
        while ($countones(~a) < 2) a = 4'($urandom);
        step(a, 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
